// File: rtl/seg_display_scanner_if.sv
// Display-side bundle between the alarm clock counters and the scanner.
// The master modport belongs to the counter/time source. The slave modport
// belongs to the display scanner.
//   min_units/min_tens/hr_units/hr_tens : BCD time digits (HH:MM)
//   blink_mask/blink_phase              : per-digit blink control (live)
//   dp_en                               : colon enable (dp of digit 2)
//   an/seg/dp                           : active-low display drive
interface seg_display_scanner_if;
    logic [3:0] min_units;
    logic [2:0] min_tens;
    logic [3:0] hr_units;
    logic [1:0] hr_tens;
    logic [3:0] blink_mask;
    logic       blink_phase;
    logic       dp_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output min_units, min_tens, hr_units, hr_tens,
        output blink_mask, blink_phase, dp_en,
        input  an, seg, dp
    );

    modport slave (
        input  min_units, min_tens, hr_units, hr_tens,
        input  blink_mask, blink_phase, dp_en,
        output an, seg, dp
    );
endinterface

// File: rtl/seg_display_scanner.sv
// 4-digit common-anode multiplexed seven-segment scanner for HH:MM.
// The four digits are snapshotted once per frame, so every frame shows one
// coherent time value. Each slot opens with an anti-ghosting guard in which
// all anodes are off. The block also does BCD decode, leading-zero blanking
// of the hour tens digit, live per-digit blinking and the colon (dp of digit 2).
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   disp  : slave side of seg_display_scanner_if (digits in, an/seg/dp out)
module seg_display_scanner #(
    parameter int unsigned REFRESH_DIV = 250000,
    parameter int unsigned GUARD       = 4,
    parameter int unsigned LZ_SUPPRESS = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    seg_display_scanner_if.slave   disp
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] P_GUARD = PW'(GUARD);

    logic [PW-1:0] p_q,    p_d;
    logic [1:0]    i_q,    i_d;
    logic [12:0]   snap_q, snap_d;
    logic [3:0]    an_q,   an_d;
    logic [6:0]    seg_q,  seg_d;
    logic          dp_q,   dp_d;

    // Snapshot layout: {hr_tens[1:0], hr_units[3:0], min_tens[2:0], min_units[3:0]}
    logic [1:0] s_hr_tens;
    logic [3:0] s_hr_units;
    logic [2:0] s_min_tens;
    logic [3:0] s_min_units;

    assign s_hr_tens   = snap_q[12:11];
    assign s_hr_units  = snap_q[10:7];
    assign s_min_tens  = snap_q[6:4];
    assign s_min_units = snap_q[3:0];

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [3:0] digit;
    logic       lit_window;
    logic       blink_blank;
    logic       lz_blank;
    logic       show;

    always_comb begin
        p_d    = p_q + PW'(1);
        i_d    = i_q;
        snap_d = snap_q;
        if (p_q == P_LAST) begin
            p_d = '0;
            i_d = i_q + 2'd1;
            // Capture on the last cycle of slot 3 so that the next frame
            // starts from one consistent time value.
            if (i_q == 2'd3) begin
                snap_d = {disp.hr_tens, disp.hr_units, disp.min_tens, disp.min_units};
            end
        end

        case (i_q)
            2'd0:    digit = s_min_units;
            2'd1:    digit = {1'b0, s_min_tens};
            2'd2:    digit = s_hr_units;
            default: digit = {2'b00, s_hr_tens};
        endcase

        // Outputs are registered from the pre-update p/i, so the guard seen
        // at the pins starts one cycle after the wrap and lasts GUARD cycles.
        lit_window  = (p_q >= P_GUARD);
        blink_blank = disp.blink_mask[i_q] & disp.blink_phase;
        lz_blank    = (LZ_SUPPRESS != 0) && (i_q == 2'd3) && (s_hr_tens == 2'd0);
        show        = lit_window && !blink_blank && !lz_blank;

        an_d  = '1;
        seg_d = '1;
        if (show) begin
            an_d  = ~(4'b0001 << i_q);
            seg_d = bcd_to_seg(digit);
        end
        dp_d = !((i_q == 2'd2) && disp.dp_en && lit_window && !blink_blank);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_q    <= '0;
            i_q    <= '0;
            snap_q <= '0;
            an_q   <= '1;
            seg_q  <= '1;
            dp_q   <= 1'b1;
        end else begin
            p_q    <= p_d;
            i_q    <= i_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign disp.an  = an_q;
    assign disp.seg = seg_q;
    assign disp.dp  = dp_q;

endmodule
